// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, sync polarity encodings and axis-length helper.
// Optional test pattern output is enabled with VGA_SYNC_TEST_PATTERN_EN (see vga_sync_gen).
package vga_timing_pkg;

   function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

   localparam int VGA_CLK_DIV = 2;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with advance/clear, plus active and sync-window decode
// of the registered count (decode is combinational; the top registers it).
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int W      = 10,
   parameter int ACTIVE = VGA_H_ACTIVE,
   parameter int FP     = VGA_H_FP,
   parameter int SYNC   = VGA_H_SYNC,
   parameter int BP     = VGA_H_BP
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         advance_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o,
   output logic         in_active_o,
   output logic         in_sync_o
);
   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (advance_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o     = count_q;
   assign wrap_o      = advance_i && !clear_i && (count_q == LAST);
   assign in_active_o = (count_q < ACT_END);
   assign in_sync_o   = (count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel divider, h/v axis counters and registered decode.
// Define VGA_SYNC_TEST_PATTERN_EN to add the 8-bar testRGB output.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int CLK_DIV  = VGA_CLK_DIV,
   parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   output logic [9:0] pixelCnt,
   output logic [8:0] lineCnt,
   output logic       hsync,
   output logic       vsync,
   output logic       active,
   output logic       pixelTick,
   output logic       frameStart
`ifdef VGA_SYNC_TEST_PATTERN_EN
   ,
   output logic [8:0] testRGB
`endif
);
   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic          tick;
   logic [9:0]    h_count, v_count;
   logic          h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;

   logic       hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
   logic [9:0] pixel_q, pixel_d;
   logic [8:0] line_q, line_d;
   logic       frame_start_q, frame_start_d, frame_arm_q, frame_arm_d;

   // Reset is folded in so CLK_DIV=1 still shows no tick while held in reset.
   assign tick = enable && !reset && (div_q == DIV_LAST);

   always_comb begin
      div_d = (!enable || (div_q == DIV_LAST)) ? '0 : div_q + 1'b1;
   end

   vga_axis_counter #(
      .W(10), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
   ) u_h (
      .clock(clock), .reset(reset), .clear_i(!enable), .advance_i(tick),
      .count_o(h_count), .wrap_o(h_wrap), .in_active_o(h_act), .in_sync_o(h_sync)
   );

   vga_axis_counter #(
      .W(10), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
   ) u_v (
      .clock(clock), .reset(reset), .clear_i(!enable), .advance_i(h_wrap),
      .count_o(v_count), .wrap_o(v_wrap), .in_active_o(v_act), .in_sync_o(v_sync)
   );

   // frameStart is armed whenever the counters are about to (re)enter the origin,
   // and disarmed by the pulse so the multi-clock stay at (0,0) pulses only once.
   always_comb begin
      hsync_d       = (enable && h_sync) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (enable && v_sync) ? SYNC_POL : ~SYNC_POL;
      active_d      = enable && h_act && v_act;
      pixel_d       = (enable && h_act) ? h_count : '0;
      line_d        = (enable && v_act) ? v_count[8:0] : '0;
      frame_start_d = enable && frame_arm_q && (h_count == '0) && (v_count == '0);
      if (!enable || v_wrap) begin
         frame_arm_d = 1'b1;
      end else if (frame_start_d) begin
         frame_arm_d = 1'b0;
      end else begin
         frame_arm_d = frame_arm_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_q         <= '0;
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         active_q      <= 1'b0;
         pixel_q       <= '0;
         line_q        <= '0;
         frame_start_q <= 1'b0;
         frame_arm_q   <= 1'b1;
      end else begin
         div_q         <= div_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         pixel_q       <= pixel_d;
         line_q        <= line_d;
         frame_start_q <= frame_start_d;
         frame_arm_q   <= frame_arm_d;
      end
   end

   assign pixelCnt   = pixel_q;
   assign lineCnt    = line_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign active     = active_q;
   assign pixelTick  = tick;
   assign frameStart = frame_start_q;

`ifdef VGA_SYNC_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

   logic [2:0] bar;
   logic [8:0] rgb_q, rgb_d;

   assign bar = 3'(h_count / BAR_W);

   // Each colour component is a 3-bit field driven by one bar-index bit ({B,G,R}).
   for (genvar gi = 0; gi < 3; gi++) begin : g_rgb
      assign rgb_d[gi*3 +: 3] = active_d ? {3{bar[gi]}} : 3'b000;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign testRGB = rgb_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a reduced-timing instance covering full frames and a default
// 640x480 instance covering the first lines, both against a cycle model.
module tb_vga_sync_gen;
   logic clock  = 1'b0;
   logic reset  = 1'b1;
   logic enable = 1'b0;
   bit   clk_run = 1'b1;

   always #5 if (clk_run) clock = ~clock;

   // Instance 0: small raster; instance 1: default parameters.
   int HA[2]  = '{16, 640};
   int HFP[2] = '{2, 16};
   int HS[2]  = '{3, 96};
   int HBP[2] = '{3, 48};
   int VA[2]  = '{6, 480};
   int VFP[2] = '{1, 10};
   int VS[2]  = '{2, 2};
   int VBP[2] = '{2, 33};
   int DIV[2] = '{3, 2};
   bit POL[2] = '{1'b1, 1'b0};

   typedef struct {
      logic       hs, vs, act, tick, fs;
      logic [9:0] px;
      logic [8:0] ln;
      logic [8:0] rgb;
   } obs_t;

   logic [9:0] px0, px1;
   logic [8:0] ln0, ln1;
   logic       hs0, hs1, vs0, vs1, act0, act1, tick0, tick1, fs0, fs1;
   logic [8:0] rgb0, rgb1;

   vga_sync_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .CLK_DIV(3), .SYNC_POL(1'b1)
   ) dut0 (
      .clock(clock), .reset(reset), .enable(enable),
      .pixelCnt(px0), .lineCnt(ln0), .hsync(hs0), .vsync(vs0),
      .active(act0), .pixelTick(tick0), .frameStart(fs0)
`ifdef VGA_SYNC_TEST_PATTERN_EN
      , .testRGB(rgb0)
`endif
   );

   vga_sync_gen dut1 (
      .clock(clock), .reset(reset), .enable(enable),
      .pixelCnt(px1), .lineCnt(ln1), .hsync(hs1), .vsync(vs1),
      .active(act1), .pixelTick(tick1), .frameStart(fs1)
`ifdef VGA_SYNC_TEST_PATTERN_EN
      , .testRGB(rgb1)
`endif
   );

`ifndef VGA_SYNC_TEST_PATTERN_EN
   assign rgb0 = '0;
   assign rgb1 = '0;
`endif

   int n_err = 0;
   int n_chk = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic obs_t observe(input int i);
      obs_t o;
      if (i == 0) begin
         o.hs = hs0; o.vs = vs0; o.act = act0; o.tick = tick0; o.fs = fs0;
         o.px = px0; o.ln = ln0; o.rgb = rgb0;
      end else begin
         o.hs = hs1; o.vs = vs1; o.act = act1; o.tick = tick1; o.fs = fs1;
         o.px = px1; o.ln = ln1; o.rgb = rgb1;
      end
      return o;
   endfunction

   // Cycle model: raster position per instance, advanced on every active edge.
   int   div_m[2], h_m[2], v_m[2];
   bit   org_m[2];
   obs_t sb0[$];
   obs_t sb1[$];

   task automatic model_step(input int i, output obs_t e);
      int htot, vtot, h, v, d, hsf, vsf;
      bit org;
      logic [2:0] bar;
      htot = HA[i] + HFP[i] + HS[i] + HBP[i];
      vtot = VA[i] + VFP[i] + VS[i] + VBP[i];
      h = h_m[i]; v = v_m[i]; d = div_m[i];
      hsf = HA[i] + HFP[i];
      vsf = VA[i] + VFP[i];
      e.hs  = (enable && h >= hsf && h < hsf + HS[i]) ? POL[i] : !POL[i];
      e.vs  = (enable && v >= vsf && v < vsf + VS[i]) ? POL[i] : !POL[i];
      e.act = enable && h < HA[i] && v < VA[i];
      e.px  = (enable && h < HA[i]) ? 10'(h) : 10'd0;
      e.ln  = (enable && v < VA[i]) ? 9'(v) : 9'd0;
      org = enable && h == 0 && v == 0;
      e.fs = org && !org_m[i];
      org_m[i] = org;
      bar = 3'(h / (HA[i] / 8));
      e.rgb = e.act ? {{3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}}} : 9'd0;
      if (!enable) begin
         d = 0; h = 0; v = 0;
      end else if (d == DIV[i] - 1) begin
         d = 0;
         if (h == htot - 1) begin
            h = 0;
            v = (v == vtot - 1) ? 0 : v + 1;
         end else begin
            h = h + 1;
         end
      end else begin
         d = d + 1;
      end
      h_m[i] = h; v_m[i] = v; div_m[i] = d;
      e.tick = enable && (d == DIV[i] - 1);
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            div_m[i] = 0; h_m[i] = 0; v_m[i] = 0; org_m[i] = 1'b0;
         end
         sb0.delete();
         sb1.delete();
      end else begin
         for (int i = 0; i < 2; i++) begin
            obs_t e;
            model_step(i, e);
            if (i == 0) sb0.push_back(e);
            else        sb1.push_back(e);
         end
      end
   end

   task automatic compare_inst(input int i);
      obs_t e, o;
      string p;
      if (i == 0) begin
         if (sb0.size() == 0) return;
         e = sb0.pop_front();
      end else begin
         if (sb1.size() == 0) return;
         e = sb1.pop_front();
      end
      o = observe(i);
      p = $sformatf("d%0d.", i);
      check({p, "hsync"}, o.hs, e.hs);
      check({p, "vsync"}, o.vs, e.vs);
      check({p, "active"}, o.act, e.act);
      check({p, "pixelTick"}, o.tick, e.tick);
      check({p, "frameStart"}, o.fs, e.fs);
      check({p, "pixelCnt"}, o.px, e.px);
      check({p, "lineCnt"}, o.ln, e.ln);
`ifdef VGA_SYNC_TEST_PATTERN_EN
      check({p, "testRGB"}, o.rgb, e.rgb);
`endif
   endtask

   int last_fs = -1;
   int px_max[2] = '{0, 0};
   int ln_max[2] = '{0, 0};

   always @(negedge clock or posedge reset) begin
      if (reset) begin
         last_fs = -1;
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) compare_inst(i);
         if (int'(px0) > px_max[0]) px_max[0] = int'(px0);
         if (int'(px1) > px_max[1]) px_max[1] = int'(px1);
         if (int'(ln0) > ln_max[0]) ln_max[0] = int'(ln0);
         if (int'(ln1) > ln_max[1]) ln_max[1] = int'(ln1);
         if (!enable) begin
            last_fs = -1;
         end else if (fs0 === 1'b1) begin
            $display("frame d0 start at cycle %0d", cyc);
            if (last_fs >= 0) check("d0.frame_period", cyc - last_fs, 24 * 11 * 3);
            last_fs = cyc;
         end
      end
   end

   task automatic check_reset(input int i, input string tag);
      obs_t o;
      o = observe(i);
      check($sformatf("d%0d.%s.hsync", i, tag), o.hs, !POL[i]);
      check($sformatf("d%0d.%s.vsync", i, tag), o.vs, !POL[i]);
      check($sformatf("d%0d.%s.active", i, tag), o.act, 0);
      check($sformatf("d%0d.%s.pixelTick", i, tag), o.tick, 0);
      check($sformatf("d%0d.%s.frameStart", i, tag), o.fs, 0);
      check($sformatf("d%0d.%s.pixelCnt", i, tag), o.px, 0);
      check($sformatf("d%0d.%s.lineCnt", i, tag), o.ln, 0);
`ifdef VGA_SYNC_TEST_PATTERN_EN
      check($sformatf("d%0d.%s.testRGB", i, tag), o.rgb, 0);
`endif
   endtask

   task automatic wait_pos(input int h, input int v);
      int k;
      k = 0;
      while (!(h_m[0] == h && v_m[0] == v) && k < 2000) begin
         @(negedge clock);
         k++;
      end
      if (!(h_m[0] == h && v_m[0] == v)) check("wait_pos_timeout", 0, 1);
   endtask

   initial begin
      int n;
      repeat (4) @(negedge clock);
      for (int i = 0; i < 2; i++) check_reset(i, "rst_run");
      #1 reset = 1'b0; enable = 1'b1;

      repeat (3400) @(negedge clock);

      wait_pos(10, 3);
      #1 enable = 1'b0;
      @(negedge clock);
      for (int i = 0; i < 2; i++) check_reset(i, "idle");
      repeat (5) @(negedge clock);
      #1 enable = 1'b1;
      n = 0;
      repeat (12) begin
         @(negedge clock);
         if (fs0 === 1'b1) n++;
      end
      check("d0.fs_once_after_enable", n, 1);
      repeat (600) @(negedge clock);

      wait_pos(8, 2);
      clk_run = 1'b0;
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) check_reset(i, "rst_async");
      #3 reset = 1'b0;
      #2 clk_run = 1'b1;
      repeat (2000) @(negedge clock);

      check("d0.pixel_max", px_max[0], 15);
      check("d0.line_max", ln_max[0], 5);
      check("d1.pixel_max", px_max[1], 639);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
